// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the pipeline registers.
package pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV      = 2'd1,
        ST_EXC_PEND = 2'd2
    } ctrl_state_e;

    // Pipeline register indices into stall/flush vectors
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_WB  = 4;
    localparam int STALL_W = 5;

    typedef logic [STALL_W-1:0] stage_vec_t;

    // Stall/flush shapes per hazard class: the stall bits cover the stages
    // up to the hazard, the flush bit lands on the first register that keeps moving.
    localparam stage_vec_t STALL_NONE  = 5'b00000;
    localparam stage_vec_t FLUSH_NONE  = 5'b00000;
    localparam stage_vec_t STALL_REDIR = 5'b00000;
    localparam stage_vec_t FLUSH_REDIR = 5'b11110;
    localparam stage_vec_t STALL_MEM   = 5'b01111;
    localparam stage_vec_t FLUSH_MEM   = 5'b10000;
    localparam stage_vec_t STALL_DIV   = 5'b00111;
    localparam stage_vec_t FLUSH_DIV   = 5'b01000;
    localparam stage_vec_t STALL_LU    = 5'b00011;
    localparam stage_vec_t FLUSH_LU    = 5'b00100;
    localparam stage_vec_t STALL_IF    = 5'b00001;
    localparam stage_vec_t FLUSH_IF    = 5'b00010;

endpackage

// File: rtl/pipe_div_timer.sv
// Divider occupancy timer: loadable down-counter that saturates at zero.
module pipe_div_timer #(
    parameter int unsigned DIV_CYCLES = 36
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic abort_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Abort wins over load, load wins over the per-cycle decrement
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (abort_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: divider timing, exception redirect, hazard priority mux.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 36
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               if_req_stall_i,
    input  logic               id_load_use_i,
    input  logic               ex_div_start_i,
    input  logic               mem_req_stall_i,
    input  logic               exc_valid_i,
    input  logic [31:0]        exc_target_i,
    output logic [STALL_W-1:0] stall_o,
    output logic [STALL_W-1:0] flush_o,
    output logic               redirect_valid_o,
    output logic [31:0]        redirect_pc_o,
    output logic               div_busy_o,
    output logic               div_done_o
);

    ctrl_state_e state_q, state_d;
    logic [31:0] tgt_q, tgt_d;

    logic cnt_zero;
    logic timer_load, timer_abort, timer_dec;
    logic in_pend, redirect, div_stall;

    pipe_div_timer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (timer_load),
        .abort_i (timer_abort),
        .dec_i   (timer_dec),
        .zero_o  (cnt_zero)
    );

    // In EXC_PEND only the D-cache stall matters; a new exception is not accepted.
    assign in_pend   = (state_q == ST_EXC_PEND);
    assign redirect  = !mem_req_stall_i && (in_pend || exc_valid_i);
    assign div_stall = ((state_q == ST_RUN) && ex_div_start_i) ||
                       ((state_q == ST_DIV) && !cnt_zero);
    assign timer_dec = (state_q == ST_DIV);

    // State register and exception target latch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state logic, divider timer control and target capture
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        tgt_d       = tgt_q;
        timer_load  = 1'b0;
        timer_abort = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (exc_valid_i) begin
                    if (mem_req_stall_i) begin
                        state_d = ST_EXC_PEND;
                        tgt_d   = exc_target_i;
                    end
                end else if (ex_div_start_i) begin
                    timer_load = 1'b1;
                    state_d    = ST_DIV;
                end
            end
            ST_DIV: begin
                if (exc_valid_i) begin
                    timer_abort = 1'b1;
                    if (mem_req_stall_i) begin
                        state_d = ST_EXC_PEND;
                        tgt_d   = exc_target_i;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (cnt_zero && !mem_req_stall_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_EXC_PEND: begin
                if (!mem_req_stall_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Priority output mux: redirect > mem stall > divider > load-use > fetch stall
    always_comb begin
        stall_o          = STALL_NONE;
        flush_o          = FLUSH_NONE;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        if (redirect) begin
            stall_o          = STALL_REDIR;
            flush_o          = FLUSH_REDIR;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = in_pend ? tgt_q : exc_target_i;
        end else if (mem_req_stall_i) begin
            stall_o = STALL_MEM;
            flush_o = FLUSH_MEM;
        end else if (div_stall) begin
            stall_o = STALL_DIV;
            flush_o = FLUSH_DIV;
        end else if (!in_pend && id_load_use_i) begin
            stall_o = STALL_LU;
            flush_o = FLUSH_LU;
        end else if (!in_pend && if_req_stall_i) begin
            stall_o = STALL_IF;
            flush_o = FLUSH_IF;
        end
    end

    assign div_busy_o = (state_q == ST_DIV);
    assign div_done_o = (state_q == ST_DIV) && cnt_zero;

endmodule
